// File: rtl/alu_result_accum.sv
// Block-summing saturating accumulator for the signed add/sub stage results.
// Collects BLOCK_LEN results, then holds the total on a valid/ready output handshake.
module alu_result_accum #(
  parameter int N         = 4,
  parameter int ACC_W     = 8,
  parameter int BLOCK_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N:0]       in_result,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] count,
  output logic             sat,
  output logic             zero,
  output logic             neg
);

  localparam logic [0:0]       ST_ACC      = 1'b0;
  localparam logic [0:0]       ST_DONE     = 1'b1;
  localparam logic [CNT_W-1:0] BLOCK_LEN_C = CNT_W'(BLOCK_LEN);
  localparam logic [ACC_W-1:0] ACC_MAX     = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN     = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] ACC_ZERO    = {ACC_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             accept_s;
  logic             sat_hit_s;
  logic [ACC_W-1:0] acc_sum_s;

  // One guard bit is enough: the two top bits of the wide sum disagree exactly on overflow.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a, input logic [N:0] b);
    logic [ACC_W:0] wide;
    wide = {a[ACC_W-1], a} + {{(ACC_W-N){b[N]}}, b};
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      if (wide[ACC_W]) begin
        sat_add = {1'b1, ACC_MIN};
      end else begin
        sat_add = {1'b1, ACC_MAX};
      end
    end else begin
      sat_add = {1'b0, wide[ACC_W-1:0]};
    end
  endfunction

  assign in_ready               = rst_n && (state_q == ST_ACC) && !clear;
  assign accept_s               = in_valid && in_ready;
  assign {sat_hit_s, acc_sum_s} = sat_add(acc_q, in_result);

  // Next-state logic: clear aborts everything, otherwise accumulate or drain.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    if (clear) begin
      state_d = ST_ACC;
      acc_d   = ACC_ZERO;
      cnt_d   = CNT_ZERO;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (accept_s) begin
            acc_d = acc_sum_s;
            sat_d = sat_q | sat_hit_s;
            cnt_d = cnt_q + CNT_ONE;
            if ((cnt_q + CNT_ONE) == BLOCK_LEN_C) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_ACC;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_ACC;
            acc_d   = ACC_ZERO;
            cnt_d   = CNT_ZERO;
            sat_d   = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = ST_ACC;
          acc_d   = ACC_ZERO;
          cnt_d   = CNT_ZERO;
          sat_d   = 1'b0;
        end
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      acc_q   <= ACC_ZERO;
      cnt_q   <= CNT_ZERO;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign acc_out   = acc_q;
  assign count     = cnt_q;
  assign sat       = sat_q;
  assign zero      = (acc_q == ACC_ZERO);
  assign neg       = acc_q[ACC_W-1];

endmodule

// File: tb/tb_alu_result_accum.sv
// Self-checking bench: dut_a (ACC_W=8) against a behavioural model, dut_b (ACC_W=6) for saturation.
module tb_alu_result_accum;

  localparam int N  = 4;
  localparam int BL = 4;

  logic clk = 1'b0;
  logic rst_n;

  logic       in_valid_a, in_ready_a, clear_a, out_valid_a, out_ready_a, sat_a, zero_a, neg_a;
  logic [4:0] in_result_a;
  logic [7:0] acc_a, count_a;

  logic       in_valid_b, in_ready_b, clear_b, out_valid_b, out_ready_b, sat_b, zero_b, neg_b;
  logic [4:0] in_result_b;
  logic [5:0] acc_b;
  logic [7:0] count_b;

  logic [20:0] obs_a;

  int  errors = 0;
  int  checks = 0;
  int  m_acc, m_cnt;
  bit  m_sat, m_done;

  always #5 clk = ~clk;

  alu_result_accum #(.N(N), .ACC_W(8), .BLOCK_LEN(BL), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_result(in_result_a), .clear(clear_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .acc_out(acc_a), .count(count_a), .sat(sat_a),
    .zero(zero_a), .neg(neg_a));

  alu_result_accum #(.N(N), .ACC_W(6), .BLOCK_LEN(BL), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_result(in_result_b), .clear(clear_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .acc_out(acc_b), .count(count_b), .sat(sat_b),
    .zero(zero_b), .neg(neg_b));

  assign obs_a = {in_ready_a, out_valid_a, sat_a, zero_a, neg_a, count_a, acc_a};

  function automatic int clamp(int v, int w);
    int mx = (1 << (w - 1)) - 1;
    int mn = -(1 << (w - 1));
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  function automatic logic [20:0] exp_a();
    logic [7:0] a8;
    logic [7:0] c8;
    a8 = m_acc[7:0];
    c8 = m_cnt[7:0];
    return {(rst_n && !m_done && !clear_a), m_done, m_sat, (m_acc == 0), (m_acc < 0), c8, a8};
  endfunction

  function automatic int rnd_val();
    return int'($urandom_range(31, 0)) - 16;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_cnt = 0; m_sat = 1'b0; m_done = 1'b0;
  endtask

  // Drive one cycle into dut_a and advance the model across the same edge.
  task automatic step_a(input bit v, input int d, input bit c, input bit r);
    int t;
    in_valid_a = v; in_result_a = d[4:0]; clear_a = c; out_ready_a = r;
    @(posedge clk);
    if (c) begin
      model_reset();
    end else if (!m_done) begin
      if (v) begin
        t = m_acc + d;
        if (clamp(t, 8) != t) m_sat = 1'b1;
        m_acc = clamp(t, 8);
        m_cnt = m_cnt + 1;
        if (m_cnt == BL) m_done = 1'b1;
      end
    end else if (r) begin
      model_reset();
    end
    #1;
  endtask

  task automatic step_b(input bit v, input int d, input bit r);
    in_valid_b = v; in_result_b = d[4:0]; out_ready_b = r;
    @(posedge clk);
    #1;
  endtask

  task automatic finish_block_a();
    while (!m_done) step_a(1'b1, rnd_val(), 1'b0, 1'b0);
    step_a(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    checks++;
    if (obs_a !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0}) begin
      errors++; $display("FAIL reset_a: got %h want %h", obs_a, {5'b00010, 16'd0});
    end
    checks++;
    if ({in_ready_b, out_valid_b, sat_b, zero_b, neg_b, count_b, acc_b} !== {5'b00010, 8'd0, 6'd0}) begin
      errors++; $display("FAIL reset_b: got rdy=%b vld=%b acc=%h", in_ready_b, out_valid_b, acc_b);
    end
  endtask

  task automatic test_basic();
    int vals[4] = '{5, -3, 15, 7};
    logic [20:0] e;
    for (int i = 0; i < 4; i++) begin
      step_a(1'b1, vals[i], 1'b0, 1'b1);
      e = exp_a(); checks++;
      if (obs_a !== e) begin errors++; $display("FAIL basic_step[%0d]: got %h want %h", i, obs_a, e); end
    end
    checks++;
    if (obs_a !== {1'b0, 1'b1, 3'b000, 8'd4, 8'h18}) begin
      errors++; $display("FAIL basic_total: got %h want %h", obs_a, {5'b01000, 8'd4, 8'h18});
    end
    step_a(1'b0, 0, 1'b0, 1'b1);
    checks++;
    if (obs_a !== {1'b1, 1'b0, 3'b010, 8'd0, 8'd0}) begin
      errors++; $display("FAIL basic_handshake: got %h want %h", obs_a, {5'b10010, 16'd0});
    end
  endtask

  task automatic test_hold();
    int vals[4] = '{3, -3, 4, -4};
    for (int i = 0; i < 4; i++) step_a(1'b1, vals[i], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step_a(1'b1, rnd_val(), 1'b0, 1'b0);
      checks++;
      if (obs_a !== {1'b0, 1'b1, 3'b010, 8'd4, 8'd0}) begin
        errors++; $display("FAIL hold[%0d]: got %h want %h", i, obs_a, {5'b01010, 8'd4, 8'd0});
      end
    end
    step_a(1'b1, 9, 1'b0, 1'b1);
    checks++;
    if (obs_a !== {1'b1, 1'b0, 3'b010, 8'd0, 8'd0}) begin
      errors++; $display("FAIL hold_release: got %h want %h", obs_a, {5'b10010, 16'd0});
    end
    step_a(1'b1, 2, 1'b0, 1'b0);
    checks++;
    if (obs_a !== {1'b1, 1'b0, 3'b000, 8'd1, 8'd2}) begin
      errors++; $display("FAIL hold_next_block: got %h want %h", obs_a, {5'b10000, 8'd1, 8'd2});
    end
    finish_block_a();
  endtask

  task automatic test_clear();
    step_a(1'b1, 7, 1'b0, 1'b0);
    step_a(1'b1, 7, 1'b0, 1'b0);
    step_a(1'b1, 5, 1'b1, 1'b0);
    checks++;
    if (obs_a !== {1'b0, 1'b0, 3'b010, 8'd0, 8'd0}) begin
      errors++; $display("FAIL clear_mid: got %h want %h", obs_a, {5'b00010, 16'd0});
    end
    for (int i = 0; i < 4; i++) step_a(1'b1, 1, 1'b0, 1'b0);
    checks++;
    if (obs_a !== {1'b0, 1'b1, 3'b000, 8'd4, 8'd4}) begin
      errors++; $display("FAIL clear_next_block: got %h want %h", obs_a, {5'b01000, 8'd4, 8'd4});
    end
    step_a(1'b0, 0, 1'b1, 1'b1);
    checks++;
    if (obs_a !== {1'b0, 1'b0, 3'b010, 8'd0, 8'd0}) begin
      errors++; $display("FAIL clear_done: got %h want %h", obs_a, {5'b00010, 16'd0});
    end
    step_a(1'b0, 0, 1'b0, 1'b0);
    checks++;
    if (obs_a !== exp_a()) begin errors++; $display("FAIL clear_after: got %h want %h", obs_a, exp_a()); end
  endtask

  task automatic test_back_to_back();
    bit want;
    for (int i = 0; i < 2 * (BL + 1); i++) begin
      step_a(1'b1, rnd_val(), 1'b0, 1'b1);
      want = (((i + 1) % (BL + 1)) != BL);
      checks++;
      if (in_ready_a !== want) begin
        errors++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, in_ready_a, want);
      end
    end
    checks++;
    if (obs_a !== exp_a()) begin errors++; $display("FAIL b2b_end: got %h want %h", obs_a, exp_a()); end
  endtask

  task automatic test_saturation();
    int         sv[4] = '{15, 15, 15, -16};
    logic [5:0] sx[4] = '{6'd15, 6'd30, 6'd31, 6'd15};
    bit         ss[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [5:0] nx[4] = '{6'h30, 6'h20, 6'h20, 6'h20};
    bit         ns[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    clear_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step_b(1'b1, sv[i], 1'b0);
      checks++;
      if ({acc_b, sat_b} !== {sx[i], ss[i]}) begin
        errors++; $display("FAIL sat_pos[%0d]: got acc=%h sat=%b want acc=%h sat=%b", i, acc_b, sat_b, sx[i], ss[i]);
      end
    end
    checks++;
    if (out_valid_b !== 1'b1) begin errors++; $display("FAIL sat_pos_valid: got %b want 1", out_valid_b); end
    step_b(1'b0, 0, 1'b1);
    checks++;
    if ({acc_b, sat_b, out_valid_b} !== {6'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sat_handshake: got acc=%h sat=%b vld=%b want 0 0 0", acc_b, sat_b, out_valid_b);
    end
    for (int i = 0; i < 4; i++) begin
      step_b(1'b1, -16, 1'b0);
      checks++;
      if ({acc_b, sat_b} !== {nx[i], ns[i]}) begin
        errors++; $display("FAIL sat_neg[%0d]: got acc=%h sat=%b want acc=%h sat=%b", i, acc_b, sat_b, nx[i], ns[i]);
      end
    end
    checks++;
    if ({neg_b, out_valid_b, zero_b} !== 3'b110) begin
      errors++; $display("FAIL sat_neg_flags: got neg=%b vld=%b zero=%b want 1 1 0", neg_b, out_valid_b, zero_b);
    end
    step_b(1'b0, 0, 1'b1);
  endtask

  task automatic test_random();
    logic [20:0] e;
    for (int i = 0; i < 400; i++) begin
      step_a(($urandom % 4) != 0, rnd_val(), ($urandom % 20) == 0, ($urandom % 2) == 1);
      e = exp_a(); checks++;
      if (obs_a !== e) begin errors++; $display("FAIL random[%0d]: got %h want %h", i, obs_a, e); end
    end
    step_a(1'b0, 0, 1'b1, 1'b0);
    step_a(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    step_a(1'b1, 7, 1'b0, 1'b0);
    step_a(1'b1, 7, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_a !== {1'b0, 1'b0, 3'b010, 8'd0, 8'd0}) begin
      errors++; $display("FAIL async_mid: got %h want %h", obs_a, {5'b00010, 16'd0});
    end
    model_reset();
    in_valid_a = 1'b0; clear_a = 1'b0; out_ready_a = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready_a !== 1'b1) begin errors++; $display("FAIL async_release_ready: got %b want 1", in_ready_a); end
    step_a(1'b1, 6, 1'b0, 1'b0);
    checks++;
    if (obs_a !== {1'b1, 1'b0, 3'b000, 8'd1, 8'd6}) begin
      errors++; $display("FAIL async_first: got %h want %h", obs_a, {5'b10000, 8'd1, 8'd6});
    end
    for (int i = 0; i < 3; i++) step_a(1'b1, 1, 1'b0, 1'b0);
    checks++;
    if (obs_a !== {1'b0, 1'b1, 3'b000, 8'd4, 8'd9}) begin
      errors++; $display("FAIL async_fill: got %h want %h", obs_a, {5'b01000, 8'd4, 8'd9});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_a !== {1'b0, 1'b0, 3'b010, 8'd0, 8'd0}) begin
      errors++; $display("FAIL async_done: got %h want %h", obs_a, {5'b00010, 16'd0});
    end
    model_reset();
    in_valid_a = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step_a(1'b1, -5, 1'b0, 1'b0);
    checks++;
    if (obs_a !== {1'b1, 1'b0, 3'b001, 8'd1, 8'hFB}) begin
      errors++; $display("FAIL async_done_first: got %h want %h", obs_a, {5'b10001, 8'd1, 8'hFB});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid_a = 1'b0; in_result_a = 5'd0; clear_a = 1'b0; out_ready_a = 1'b0;
    in_valid_b = 1'b0; in_result_b = 5'd0; clear_b = 1'b0; out_ready_b = 1'b0;
    model_reset();
    #12;
    test_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_basic();
    test_hold();
    test_clear();
    test_back_to_back();
    test_saturation();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
